// File: rtl/line_fetch_arbiter.sv
// Round-robin line fetcher: walks each enabled channel through LINES_PER_FRAME
// single-outstanding memory reads and pushes every returned line into that channel's FIFO.
module line_fetch_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int LINE_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINES_PER_FRAME = 4096,
  parameter int LINE_BYTES      = LINE_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_full,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic                         mem_rvalid,
  input  logic [LINE_WIDTH-1:0]        mem_rdata,
  output logic [NUM_CH-1:0]            fifo_we,
  output logic [LINE_WIDTH-1:0]        fifo_line,
  output logic                         busy,
  output logic [NUM_CH-1:0]            frame_done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(LINES_PER_FRAME + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(LINE_BYTES);
  localparam logic [CNT_W-1:0]      LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [NUM_CH-1:0]     CH0_BIT   = NUM_CH'(1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_WAIT,
    ST_WRITE
  } state_t;

  state_t                 state;
  logic [CH_W-1:0]        rr_ptr;
  logic [CH_W-1:0]        gnt;
  logic [CNT_W-1:0]       cnt      [NUM_CH];
  logic [ADDR_WIDTH-1:0]  base_lat [NUM_CH];
  logic [NUM_CH-1:0]      en_lat;
  logic [NUM_CH-1:0]      done;
  logic [NUM_CH-1:0]      eligible;
  logic [CH_W-1:0]        pick;
  logic                   pick_valid;
  int                     scan;

  assign eligible = en_lat & ~done & ~ch_full;

  // Scan downward from the farthest offset so the channel nearest rr_ptr wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan       = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan = (int'(rr_ptr) + i) % NUM_CH;
      if (eligible[scan]) begin
        pick_valid = 1'b1;
        pick       = CH_W'(scan);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      en_lat     <= '0;
      done       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fifo_we    <= '0;
      fifo_line  <= '0;
      busy       <= 1'b0;
      frame_done <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k]      <= '0;
        base_lat[k] <= '0;
      end
    end else begin
      frame_done <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_CH; k++) begin
              base_lat[k] <= base_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
              cnt[k]      <= '0;
            end
            en_lat <= ch_enable;
            done   <= '0;
            busy   <= 1'b1;
            state  <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (pick_valid) begin
            gnt      <= pick;
            rr_ptr   <= (pick == LAST_CH) ? '0 : pick + CH_W'(1);
            mem_req  <= 1'b1;
            mem_addr <= base_lat[pick] + ADDR_WIDTH'(cnt[pick]) * LINE_INC;
            state    <= ST_REQ;
          end else if ((en_lat & ~done) == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            fifo_line <= mem_rdata;
            fifo_we   <= CH0_BIT << gnt;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The done pulse lands in the following ARB cycle, never alongside the write strobe.
          fifo_we  <= '0;
          cnt[gnt] <= cnt[gnt] + CNT_W'(1);
          if (cnt[gnt] == LAST_LINE) begin
            done[gnt]  <= 1'b1;
            frame_done <= CH0_BIT << gnt;
          end
          state <= ST_ARB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed bench for line_fetch_arbiter: a negedge memory responder plus an event
// monitor log addresses, writes and done pulses, which are compared to hand-derived lists.
module tb_line_fetch_arbiter;

  localparam int NUM_CH = 2;
  localparam int LW     = 32;
  localparam int AW     = 32;
  localparam int LPF    = 3;

  typedef logic [31:0] word_q_t[$];

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NUM_CH*AW-1:0] base_addr;
  logic [NUM_CH-1:0]    ch_enable;
  logic [NUM_CH-1:0]    ch_full;
  logic                 mem_req;
  logic [AW-1:0]        mem_addr;
  logic                 mem_ack = 1'b0;
  logic                 mem_rvalid = 1'b0;
  logic [LW-1:0]        mem_rdata = '0;
  logic [NUM_CH-1:0]    fifo_we;
  logic [LW-1:0]        fifo_line;
  logic                 busy;
  logic [NUM_CH-1:0]    frame_done;

  int checks = 0;
  int failures = 0;

  word_q_t addrLog, weLog, doneLog;
  int busyCycles = 0, stableErrs = 0, dataErrs = 0, fullWrErrs = 0, coincideErrs = 0;
  int reqRun = 0, lastReqRun = 0, reqAge = 0, dueIn = 0;
  int ackDelay = 0, rvalidDelay = 0;
  bit duePending = 1'b0, strayRvalid = 1'b0;
  logic [31:0] prevAddr = '0, lastAckAddr = '0, dueAddr = '0;

  line_fetch_arbiter #(
    .NUM_CH(NUM_CH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .LINES_PER_FRAME(LPF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .ch_enable(ch_enable), .ch_full(ch_full), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .fifo_we(fifo_we), .fifo_line(fifo_line),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lineData(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Monitor first, then the memory model answers for the coming posedge.
  always @(negedge clk) begin
    if (busy) busyCycles++;
    if (mem_req) begin
      if (reqRun > 0 && mem_addr !== prevAddr) stableErrs++;
      prevAddr = mem_addr;
      reqRun++;
    end else begin
      reqRun = 0;
    end
    if (fifo_we != '0) begin
      weLog.push_back(32'(fifo_we));
      if (fifo_line !== lineData(lastAckAddr)) dataErrs++;
      if ((fifo_we & ch_full) != '0) fullWrErrs++;
    end
    if (frame_done != '0) doneLog.push_back(32'(frame_done));
    if ((frame_done & fifo_we) != '0) coincideErrs++;

    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (duePending) begin
      if (dueIn == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = lineData(dueAddr);
        duePending = 1'b0;
      end else begin
        dueIn--;
      end
    end
    if (mem_req && !duePending) begin
      if (strayRvalid && reqAge == 1 && !mem_rvalid) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (reqAge >= ackDelay) begin
        mem_ack     = 1'b1;
        duePending  = 1'b1;
        dueIn       = rvalidDelay;
        dueAddr     = mem_addr;
        lastAckAddr = mem_addr;
        lastReqRun  = reqRun;
        addrLog.push_back(mem_addr);
        reqAge      = 0;
      end else begin
        reqAge++;
      end
    end else if (!mem_req) begin
      reqAge = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkLog(input string tag, input word_q_t got, input word_q_t exp);
    checkOutput({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hFFFF_FFFF, exp[i]);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycles(2);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] en);
    ch_enable  = en;
    addrLog.delete();
    weLog.delete();
    doneLog.delete();
    busyCycles = 0;
    start = 1'b1;
    stepCycles(1);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) stepCycles(1);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic waitLines(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && weLog.size() < n; i++) stepCycles(1);
    checkOutput({tag, "_lines"}, 32'(weLog.size()), 32'(n));
  endtask

  // Both channels, line-interleaved; four cycles per line plus the closing arbitration.
  task automatic runBothChannels(input string tag, input bit midStart);
    base_addr = {32'h2000, 32'h1000};
    applyStimulus(2'b11);
    if (midStart) begin
      stepCycles(6);
      base_addr = {32'hF000, 32'hE000};
      ch_enable = 2'b00;
      start = 1'b1;
      stepCycles(1);
      start = 1'b0;
      stepCycles(5);
      start = 1'b1;
      stepCycles(1);
      start = 1'b0;
    end
    waitIdle(tag, 100);
    checkLog({tag, "_addr"}, addrLog, '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008});
    checkLog({tag, "_we"}, weLog, '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2});
    checkLog({tag, "_done"}, doneLog, '{32'd1, 32'd2});
    checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'd25);
    base_addr = {32'h2000, 32'h1000};
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = {32'h2000, 32'h1000};
    ch_enable = 2'b11;
    ch_full   = 2'b00;
    stepCycles(3);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_fifo_we", 32'(fifo_we), 32'd0);
    checkOutput("rst_fifo_line", fifo_line, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    stepCycles(1);

    runBothChannels("s1", 1'b0);

    // Channel 0 held full: channel 1 runs alone, then channel 0 after release.
    doReset();
    ch_full = 2'b01;
    applyStimulus(2'b11);
    waitLines("s2", 3, 60);
    stepCycles(8);
    checkOutput("s2_stall_busy", 32'(busy), 32'd1);
    checkOutput("s2_stall_addrs", 32'(addrLog.size()), 32'd3);
    ch_full = 2'b00;
    waitIdle("s2", 100);
    checkLog("s2_addr", addrLog, '{32'h2000, 32'h2004, 32'h2008, 32'h1000, 32'h1004, 32'h1008});
    checkLog("s2_we", weLog, '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1});
    checkOutput("s2_full_writes", 32'(fullWrErrs), 32'd0);

    doReset();
    applyStimulus(2'b01);
    waitIdle("s3", 100);
    checkLog("s3_addr", addrLog, '{32'h1000, 32'h1004, 32'h1008});
    checkLog("s3_done", doneLog, '{32'd1});
    checkOutput("s3_busy_cycles", 32'(busyCycles), 32'd13);

    // Slow acceptance with a stray read-valid while the request is still pending.
    doReset();
    ackDelay    = 5;
    strayRvalid = 1'b1;
    applyStimulus(2'b01);
    waitIdle("s4", 200);
    checkLog("s4_addr", addrLog, '{32'h1000, 32'h1004, 32'h1008});
    checkLog("s4_we", weLog, '{32'd1, 32'd1, 32'd1});
    checkOutput("s4_req_hold", 32'(lastReqRun), 32'd6);
    checkOutput("s4_addr_stable", 32'(stableErrs), 32'd0);
    checkOutput("s4_data", 32'(dataErrs), 32'd0);
    ackDelay    = 0;
    strayRvalid = 1'b0;

    // Reset lands while the read is outstanding; its late data must be dropped.
    doReset();
    rvalidDelay = 3;
    applyStimulus(2'b01);
    for (int i = 0; i < 20 && addrLog.size() == 0; i++) stepCycles(1);
    checkOutput("s5_in_wait", 32'(mem_req), 32'd0);
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    rvalidDelay = 0;
    stepCycles(8);
    checkOutput("s5_mem_req", 32'(mem_req), 32'd0);
    checkOutput("s5_mem_addr", mem_addr, 32'd0);
    checkOutput("s5_fifo_line", fifo_line, 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    checkOutput("s5_no_write", 32'(weLog.size()), 32'd0);
    applyStimulus(2'b01);
    waitIdle("s5_restart", 100);
    checkLog("s5_addr", addrLog, '{32'h1000, 32'h1004, 32'h1008});

    doReset();
    runBothChannels("s6_busy_start", 1'b1);
    runBothChannels("s6_repeat", 1'b0);

    checkOutput("all_coincide", 32'(coincideErrs), 32'd0);
    checkOutput("all_full_writes", 32'(fullWrErrs), 32'd0);
    checkOutput("all_data", 32'(dataErrs), 32'd0);
    checkOutput("all_addr_stable", 32'(stableErrs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
